// File: rtl/galaga_pixel_compositor.sv
// Two-stage pixel compositor: per-frame object snapshot, box hit tests, colour priority
// and per-frame collision accumulation published on the frame_end marker.
module galaga_pixel_compositor #(
   parameter int N_ENEMY   = 15,
   parameter int N_EBULLET = 31,
   parameter int N_PBULLET = 15,
   parameter int X_W       = 10,
   parameter int Y_W       = 9,
   parameter int ENEMY_W   = 36,
   parameter int ENEMY_H   = 24,
   parameter int PLAYER_W  = 24,
   parameter int PLAYER_H  = 36,
   parameter int BULLET_W  = 4,
   parameter int BULLET_H  = 16,
   parameter int PLAYER_Y  = 280
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           pix_valid_in,
   input  logic [X_W-1:0]                 n_PixelPos_x,
   input  logic [Y_W-1:0]                 n_PixelPos_y,
   input  logic                           frame_end,
   input  logic [N_ENEMY-1:0]             enemyState,
   input  logic [N_ENEMY*(X_W+Y_W)-1:0]   enemyPosition,
   input  logic [N_EBULLET-1:0]           enemyBulletState,
   input  logic [N_EBULLET*(X_W+Y_W)-1:0] enemyBulletPosition,
   input  logic                           playerState,
   input  logic [X_W-1:0]                 playerPosition,
   input  logic [N_PBULLET-1:0]           playerBulletState,
   input  logic [N_PBULLET*(X_W+Y_W)-1:0] playerBulletPosition,
   output logic                           pix_valid_out,
   output logic [2:0]                     pixelState,
   output logic                           coll_valid,
   output logic [N_ENEMY-1:0]             enemy_hit,
   output logic [N_PBULLET-1:0]           pbullet_hit,
   output logic                           player_hit
);

   localparam int E = X_W + Y_W;

   localparam logic [X_W:0]   ENEMY_WX  = ENEMY_W[X_W:0];
   localparam logic [Y_W:0]   ENEMY_HY  = ENEMY_H[Y_W:0];
   localparam logic [X_W:0]   PLAYER_WX = PLAYER_W[X_W:0];
   localparam logic [Y_W:0]   PLAYER_HY = PLAYER_H[Y_W:0];
   localparam logic [X_W:0]   BULLET_WX = BULLET_W[X_W:0];
   localparam logic [Y_W:0]   BULLET_HY = BULLET_H[Y_W:0];
   localparam logic [Y_W-1:0] PLAYER_YV = PLAYER_Y[Y_W-1:0];

   // One extra bit on the far edge so boxes near the right/bottom border never wrap.
   function automatic logic hitBox(
      input logic           act,
      input logic [X_W-1:0] px,
      input logic [Y_W-1:0] py,
      input logic [X_W-1:0] ox,
      input logic [Y_W-1:0] oy,
      input logic [X_W:0]   w,
      input logic [Y_W:0]   h
   );
      logic [X_W:0] pxE, oxE;
      logic [Y_W:0] pyE, oyE;
      pxE = {1'b0, px};
      oxE = {1'b0, ox};
      pyE = {1'b0, py};
      oyE = {1'b0, oy};
      return act && (pxE >= oxE) && (pxE < oxE + w) && (pyE >= oyE) && (pyE < oyE + h);
   endfunction

   function automatic logic [2:0] priorityColour(
      input logic en,
      input logic eb,
      input logic pl,
      input logic pb
   );
      if (en)      return 3'd4;
      else if (eb) return 3'd3;
      else if (pl) return 3'd1;
      else if (pb) return 3'd2;
      return 3'd0;
   endfunction

   logic [N_ENEMY-1:0]             enemyStateSh;
   logic [N_ENEMY*E-1:0]           enemyPosSh;
   logic [N_EBULLET-1:0]           ebStateSh;
   logic [N_EBULLET*E-1:0]         ebPosSh;
   logic                           playerStateSh;
   logic [X_W-1:0]                 playerPosSh;
   logic [N_PBULLET-1:0]           pbStateSh;
   logic [N_PBULLET*E-1:0]         pbPosSh;

   always_ff @(posedge clk) begin
      if (reset) begin
         enemyStateSh  <= '0;
         ebStateSh     <= '0;
         playerStateSh <= 1'b0;
         pbStateSh     <= '0;
      end else if (frame_end) begin
         enemyStateSh  <= enemyState;
         ebStateSh     <= enemyBulletState;
         playerStateSh <= playerState;
         pbStateSh     <= playerBulletState;
      end
   end

   always_ff @(posedge clk) begin
      if (frame_end) begin
         enemyPosSh  <= enemyPosition;
         ebPosSh     <= enemyBulletPosition;
         playerPosSh <= playerPosition;
         pbPosSh     <= playerBulletPosition;
      end
   end

   // Stage 1: hit tests against the shadow copies
   logic [N_ENEMY-1:0]   hitEnemy;
   logic [N_EBULLET-1:0] hitEb;
   logic [N_PBULLET-1:0] hitPb;
   logic                 hitPlayer;

   always_comb begin
      hitEnemy = '0;
      hitEb    = '0;
      hitPb    = '0;
      for (int i = 0; i < N_ENEMY; i++)
         hitEnemy[i] = hitBox(enemyStateSh[i], n_PixelPos_x, n_PixelPos_y,
                              enemyPosSh[i*E +: X_W], enemyPosSh[i*E+X_W +: Y_W],
                              ENEMY_WX, ENEMY_HY);
      for (int i = 0; i < N_EBULLET; i++)
         hitEb[i] = hitBox(ebStateSh[i], n_PixelPos_x, n_PixelPos_y,
                           ebPosSh[i*E +: X_W], ebPosSh[i*E+X_W +: Y_W],
                           BULLET_WX, BULLET_HY);
      for (int i = 0; i < N_PBULLET; i++)
         hitPb[i] = hitBox(pbStateSh[i], n_PixelPos_x, n_PixelPos_y,
                           pbPosSh[i*E +: X_W], pbPosSh[i*E+X_W +: Y_W],
                           BULLET_WX, BULLET_HY);
      hitPlayer = hitBox(playerStateSh, n_PixelPos_x, n_PixelPos_y,
                         playerPosSh, PLAYER_YV, PLAYER_WX, PLAYER_HY);
   end

   logic                 vld_p1;
   logic                 frm_p1;
   logic [N_ENEMY-1:0]   hitEnemy_p1;
   logic [N_EBULLET-1:0] hitEb_p1;
   logic [N_PBULLET-1:0] hitPb_p1;
   logic                 hitPlayer_p1;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1 <= 1'b0;
         frm_p1 <= 1'b0;
      end else begin
         vld_p1 <= pix_valid_in;
         frm_p1 <= frame_end;
      end
   end

   always_ff @(posedge clk) begin
      hitEnemy_p1  <= hitEnemy;
      hitEb_p1     <= hitEb;
      hitPb_p1     <= hitPb;
      hitPlayer_p1 <= hitPlayer;
   end

   // Stage 2: colour priority, collision accumulation and frame publish
   logic                 anyEnemy, anyEb, anyPb;
   logic [N_ENEMY-1:0]   enemyAcc_p2, enemyAccNext;
   logic [N_PBULLET-1:0] pbAcc_p2, pbAccNext;
   logic                 playerAcc_p2, playerAccNext;

   always_comb begin
      anyEnemy      = |hitEnemy_p1;
      anyEb         = |hitEb_p1;
      anyPb         = |hitPb_p1;
      enemyAccNext  = enemyAcc_p2 | ({N_ENEMY{vld_p1 & anyPb}} & hitEnemy_p1);
      pbAccNext     = pbAcc_p2 | ({N_PBULLET{vld_p1 & anyEnemy}} & hitPb_p1);
      playerAccNext = playerAcc_p2 | (vld_p1 & hitPlayer_p1 & (anyEnemy | anyEb));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pix_valid_out <= 1'b0;
         pixelState    <= 3'd0;
         coll_valid    <= 1'b0;
         enemy_hit     <= '0;
         pbullet_hit   <= '0;
         player_hit    <= 1'b0;
         enemyAcc_p2   <= '0;
         pbAcc_p2      <= '0;
         playerAcc_p2  <= 1'b0;
      end else begin
         pix_valid_out <= vld_p1;
         pixelState    <= vld_p1 ? priorityColour(anyEnemy, anyEb, hitPlayer_p1, anyPb) : 3'd0;
         coll_valid    <= frm_p1;
         if (frm_p1) begin
            enemy_hit    <= enemyAccNext;
            pbullet_hit  <= pbAccNext;
            player_hit   <= playerAccNext;
            enemyAcc_p2  <= '0;
            pbAcc_p2     <= '0;
            playerAcc_p2 <= 1'b0;
         end else begin
            enemyAcc_p2  <= enemyAccNext;
            pbAcc_p2     <= pbAccNext;
            playerAcc_p2 <= playerAccNext;
         end
      end
   end

endmodule

// File: tb/tb_galaga_pixel_compositor.sv
// Bench for galaga_pixel_compositor: fixed vectors, hand sequences and random traffic
// compared against a frame-level behavioural model of colours and collision flags.
module tb_galaga_pixel_compositor;

   localparam int NE = 15, NEB = 31, NPB = 15, XW = 10, YW = 9, E = XW + YW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset, pix_valid_in, frame_end, playerState;
   logic [XW-1:0]     n_PixelPos_x, playerPosition;
   logic [YW-1:0]     n_PixelPos_y;
   logic [NE-1:0]     enemyState;
   logic [NE*E-1:0]   enemyPosition;
   logic [NEB-1:0]    enemyBulletState;
   logic [NEB*E-1:0]  enemyBulletPosition;
   logic [NPB-1:0]    playerBulletState;
   logic [NPB*E-1:0]  playerBulletPosition;
   logic              pix_valid_out, coll_valid, player_hit;
   logic [2:0]        pixelState;
   logic [NE-1:0]     enemy_hit;
   logic [NPB-1:0]    pbullet_hit;

   galaga_pixel_compositor dut (
      .clk(clk), .reset(reset), .pix_valid_in(pix_valid_in),
      .n_PixelPos_x(n_PixelPos_x), .n_PixelPos_y(n_PixelPos_y), .frame_end(frame_end),
      .enemyState(enemyState), .enemyPosition(enemyPosition),
      .enemyBulletState(enemyBulletState), .enemyBulletPosition(enemyBulletPosition),
      .playerState(playerState), .playerPosition(playerPosition),
      .playerBulletState(playerBulletState), .playerBulletPosition(playerBulletPosition),
      .pix_valid_out(pix_valid_out), .pixelState(pixelState), .coll_valid(coll_valid),
      .enemy_hit(enemy_hit), .pbullet_hit(pbullet_hit), .player_hit(player_hit)
   );

   int errors = 0;
   int checks = 0;

   // Object tables as driven (t*) and as latched at the last frame_end (s*)
   bit tEnAct[NE];  int tEnX[NE];  int tEnY[NE];
   bit tEbAct[NEB]; int tEbX[NEB]; int tEbY[NEB];
   bit tPbAct[NPB]; int tPbX[NPB]; int tPbY[NPB];
   bit tPlAct;      int tPlX;
   bit sEnAct[NE];  int sEnX[NE];  int sEnY[NE];
   bit sEbAct[NEB]; int sEbX[NEB]; int sEbY[NEB];
   bit sPbAct[NPB]; int sPbX[NPB]; int sPbY[NPB];
   bit sPlAct;      int sPlX;

   logic [NE-1:0]  accEn, heldEn;
   logic [NPB-1:0] accPb, heldPb;
   bit             accPl, heldPl;

   typedef struct {
      bit             vld;
      int             colour;
      bit             cv;
      logic [NE-1:0]  en;
      logic [NPB-1:0] pb;
      bit             pl;
      string          tag;
   } exp_t;
   exp_t q[$];

   typedef struct {int x; int y; int colour;} vec_t;
   vec_t vecs[9];

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic setEnemy(input int i, input bit a, input int px, input int py);
      tEnAct[i] = a; tEnX[i] = px; tEnY[i] = py;
      enemyState[i] = a;
      enemyPosition[i*E +: E] = {9'(py), 10'(px)};
   endtask

   task automatic setEb(input int i, input bit a, input int px, input int py);
      tEbAct[i] = a; tEbX[i] = px; tEbY[i] = py;
      enemyBulletState[i] = a;
      enemyBulletPosition[i*E +: E] = {9'(py), 10'(px)};
   endtask

   task automatic setPb(input int i, input bit a, input int px, input int py);
      tPbAct[i] = a; tPbX[i] = px; tPbY[i] = py;
      playerBulletState[i] = a;
      playerBulletPosition[i*E +: E] = {9'(py), 10'(px)};
   endtask

   task automatic setPlayer(input bit a, input int px);
      tPlAct = a; tPlX = px;
      playerState = a;
      playerPosition = 10'(px);
   endtask

   task automatic clearAll();
      for (int i = 0; i < NE; i++)  setEnemy(i, 0, 0, 0);
      for (int i = 0; i < NEB; i++) setEb(i, 0, 0, 0);
      for (int i = 0; i < NPB; i++) setPb(i, 0, 0, 0);
      setPlayer(0, 0);
   endtask

   function automatic bit inBox(bit a, int px, int py, int ox, int oy, int w, int h);
      return a && px >= ox && px < ox + w && py >= oy && py < oy + h;
   endfunction

   task automatic doCycle(input bit pv, input int px, input int py, input bit fe,
                          input int forceColour = -1, input string tag = "pixel");
      exp_t e;
      logic [NE-1:0]  hE;
      logic [NEB-1:0] hEb;
      logic [NPB-1:0] hP;
      bit             hPl;
      pix_valid_in = pv; n_PixelPos_x = 10'(px); n_PixelPos_y = 9'(py); frame_end = fe;
      hE = '0; hEb = '0; hP = '0; hPl = 0;
      if (pv) begin
         for (int i = 0; i < NE; i++)  hE[i]  = inBox(sEnAct[i], px, py, sEnX[i], sEnY[i], 36, 24);
         for (int i = 0; i < NEB; i++) hEb[i] = inBox(sEbAct[i], px, py, sEbX[i], sEbY[i], 4, 16);
         for (int i = 0; i < NPB; i++) hP[i]  = inBox(sPbAct[i], px, py, sPbX[i], sPbY[i], 4, 16);
         hPl = inBox(sPlAct, px, py, sPlX, 280, 24, 36);
         if (|hP) accEn |= hE;
         if (|hE) accPb |= hP;
         if (hPl && ((|hE) || (|hEb))) accPl = 1;
      end
      e.vld = pv;
      e.tag = tag;
      if (!pv)               e.colour = 0;
      else if (forceColour >= 0) e.colour = forceColour;
      else if (|hE)          e.colour = 4;
      else if (|hEb)         e.colour = 3;
      else if (hPl)          e.colour = 1;
      else if (|hP)          e.colour = 2;
      else                   e.colour = 0;
      e.cv = fe; e.en = accEn; e.pb = accPb; e.pl = accPl;
      if (fe) begin
         accEn = '0; accPb = '0; accPl = 0;
         sEnAct = tEnAct; sEnX = tEnX; sEnY = tEnY;
         sEbAct = tEbAct; sEbX = tEbX; sEbY = tEbY;
         sPbAct = tPbAct; sPbX = tPbX; sPbY = tPbY;
         sPlAct = tPlAct; sPlX = tPlX;
      end
      q.push_back(e);
      @(posedge clk); #1;
      pix_valid_in = 0; frame_end = 0;
      if (q.size() >= 2) begin
         e = q.pop_front();
         check({e.tag, " pix_valid_out"}, pix_valid_out, e.vld);
         check({e.tag, " pixelState"}, pixelState, e.colour);
         check({e.tag, " coll_valid"}, coll_valid, e.cv);
         if (e.cv) begin heldEn = e.en; heldPb = e.pb; heldPl = e.pl; end
         check({e.tag, " enemy_hit"}, enemy_hit, heldEn);
         check({e.tag, " pbullet_hit"}, pbullet_hit, heldPb);
         check({e.tag, " player_hit"}, player_hit, heldPl);
      end
   endtask

   task automatic doReset();
      exp_t idle;
      reset = 1; pix_valid_in = 1; n_PixelPos_x = 10'd100; n_PixelPos_y = 9'd50; frame_end = 0;
      @(posedge clk); #1;
      check("reset pix_valid_out", pix_valid_out, 0);
      check("reset pixelState", pixelState, 0);
      check("reset coll_valid", coll_valid, 0);
      check("reset enemy_hit", enemy_hit, 0);
      check("reset pbullet_hit", pbullet_hit, 0);
      check("reset player_hit", player_hit, 0);
      reset = 0; pix_valid_in = 0;
      q.delete();
      idle.vld = 0; idle.colour = 0; idle.cv = 0; idle.en = '0; idle.pb = '0; idle.pl = 0;
      idle.tag = "post-reset";
      q.push_back(idle);
      accEn = '0; accPb = '0; accPl = 0;
      heldEn = '0; heldPb = '0; heldPl = 0;
      for (int i = 0; i < NE; i++)  sEnAct[i] = 0;
      for (int i = 0; i < NEB; i++) sEbAct[i] = 0;
      for (int i = 0; i < NPB; i++) sPbAct[i] = 0;
      sPlAct = 0;
   endtask

   initial begin
      vecs[0] = '{100, 50, 4};  vecs[1] = '{135, 73, 4};  vecs[2] = '{136, 50, 0};
      vecs[3] = '{100, 74, 0};  vecs[4] = '{210, 290, 3}; vecs[5] = '{220, 290, 1};
      vecs[6] = '{199, 290, 0}; vecs[7] = '{5, 55, 0};    vecs[8] = '{1023, 55, 4};

      reset = 1; pix_valid_in = 0; frame_end = 0; n_PixelPos_x = '0; n_PixelPos_y = '0;
      enemyPosition = '0; enemyBulletPosition = '0; playerBulletPosition = '0;
      clearAll();
      @(posedge clk); #1;
      doReset();

      // Rendering, priority and no-wrap vectors
      setEnemy(0, 1, 100, 50);
      setEnemy(1, 1, 1000, 50);
      setPlayer(1, 200);
      setEb(5, 1, 210, 285);
      doCycle(0, 0, 0, 1);
      for (int i = 0; i < 9; i++)
         doCycle(1, vecs[i].x, vecs[i].y, 0, vecs[i].colour, $sformatf("vec%0d", i));

      // Collision frame: player bullet 3 over enemy 0
      setEnemy(1, 0, 0, 0);
      setEb(5, 0, 0, 0);
      setPb(3, 1, 110, 60);
      doCycle(0, 0, 0, 1);
      for (int yy = 48; yy < 80; yy++)
         for (int xx = 96; xx < 144; xx++)
            doCycle(1, xx, yy, 0);
      setPb(3, 0, 110, 60);
      doCycle(0, 0, 0, 1);
      doCycle(0, 0, 0, 0);
      check("frame1 coll_valid", coll_valid, 1);
      check("frame1 enemy_hit", enemy_hit, 15'h0001);
      check("frame1 pbullet_hit", pbullet_hit, 15'h0008);
      check("frame1 player_hit", player_hit, 0);
      for (int xx = 96; xx < 144; xx++) doCycle(1, xx, 60, 0);
      doCycle(0, 0, 0, 1);
      doCycle(0, 0, 0, 0);
      check("frame2 coll_valid", coll_valid, 1);
      check("frame2 enemy_hit", enemy_hit, 0);
      check("frame2 pbullet_hit", pbullet_hit, 0);

      // Snapshot: a mid-frame move stays invisible until frame_end
      setEnemy(0, 1, 300, 50);
      doCycle(1, 100, 50, 0, 4, "snapOld");
      doCycle(0, 0, 0, 1);
      doCycle(1, 100, 50, 0, 0, "snapGone");
      doCycle(1, 300, 50, 0, 4, "snapNew");

      // Back-to-back frame_end pulses
      setEnemy(0, 1, 100, 50);
      setPb(3, 1, 110, 60);
      doCycle(0, 0, 0, 1);
      doCycle(1, 111, 65, 0);
      doCycle(1, 111, 65, 1);
      doCycle(1, 111, 65, 1);
      doCycle(0, 0, 0, 1);
      doCycle(0, 0, 0, 1);
      doCycle(0, 0, 0, 0);
      doCycle(0, 0, 0, 0);

      // Mid-frame reset with an overlap already accumulated
      doCycle(1, 111, 65, 0);
      doCycle(1, 112, 66, 0);
      doReset();
      clearAll();
      doCycle(1, 111, 65, 0, 0, "afterReset");
      doCycle(0, 0, 0, 1);
      doCycle(0, 0, 0, 0);
      check("resetFrame coll_valid", coll_valid, 1);
      check("resetFrame enemy_hit", enemy_hit, 0);
      check("resetFrame pbullet_hit", pbullet_hit, 0);
      check("resetFrame player_hit", player_hit, 0);

      // Random traffic against the model
      for (int c = 0; c < 4000; c++) begin
         if (c % 250 == 0) begin
            for (int i = 0; i < NE; i++)
               setEnemy(i, ($urandom % 3) == 0,
                        ($urandom % 8 == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 300),
                        $urandom_range(0, 320));
            for (int i = 0; i < NEB; i++)
               setEb(i, ($urandom % 3) == 0, $urandom_range(0, 330), $urandom_range(0, 330));
            for (int i = 0; i < NPB; i++)
               setPb(i, ($urandom % 3) == 0, $urandom_range(0, 330), $urandom_range(0, 330));
            setPlayer($urandom % 4 != 0, $urandom_range(0, 320));
         end
         if (c == 2100) doReset();
         if ($urandom % 8 == 0)
            doCycle($urandom % 4 != 0, $urandom_range(0, 1023), $urandom_range(0, 511),
                    ($urandom % 60) == 0);
         else
            doCycle($urandom % 4 != 0, $urandom_range(0, 350), $urandom_range(0, 340),
                    ($urandom % 60) == 0);
      end
      doCycle(0, 0, 0, 1);
      doCycle(0, 0, 0, 0);
      doCycle(0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/galaga_pixel_compositor.md
# galaga_pixel_compositor

Parametrised, pipelined successor to the Galaga per-pixel colour lookup. For each requested pixel it tests the pixel against the player, player bullets, enemies and enemy bullets, and returns a 3-bit colour code. Unlike the previous block, it also latches object state once per frame to prevent tearing, and it accumulates per-object collision flags across each frame. It sits between the game-logic object tables and the VGA scan-out.

## Interface
- N_ENEMY, 15, enemy slots
- N_EBULLET, 31, enemy-bullet slots
- N_PBULLET, 15, player-bullet slots
- X_W, 10, x coordinate width
- Y_W, 9, y coordinate width; object entry width E = X_W+Y_W, with x at bits [X_W-1:0] and y at [E-1:X_W]
- ENEMY_W / ENEMY_H, 36 / 24, enemy box size in pixels
- PLAYER_W / PLAYER_H, 24 / 36, player box size
- BULLET_W / BULLET_H, 4 / 16, box size for both bullet kinds
- PLAYER_Y, 280, fixed player top row

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pix_valid_in  in  1  pixel request valid
- n_PixelPos_x  in  X_W  requested x
- n_PixelPos_y  in  Y_W  requested y
- frame_end  in  1  one-cycle pulse at end of visible frame
- enemyState  in  N_ENEMY  active flags
- enemyPosition  in  N_ENEMY*E  packed entries
- enemyBulletState  in  N_EBULLET  active flags
- enemyBulletPosition  in  N_EBULLET*E  packed entries
- playerState  in  1  player active
- playerPosition  in  X_W  player x
- playerBulletState  in  N_PBULLET  active flags
- playerBulletPosition  in  N_PBULLET*E  packed entries
- pix_valid_out  out  1  pixelState valid
- pixelState  out  3  0 background, 1 player (blue), 2 player bullet (green), 3 enemy bullet (yellow), 4 enemy (red)
- coll_valid  out  1  one-cycle pulse; collision vectors updated
- enemy_hit  out  N_ENEMY  enemy i overlapped any player bullet during the frame
- pbullet_hit  out  N_PBULLET  player bullet j overlapped any enemy during the frame
- player_hit  out  1  player overlapped any enemy or enemy bullet during the frame

## Operation
- **Shadow registers.** All state and position inputs are copied into shadow registers on every edge where frame_end=1. Rendering and collision logic use only the shadow copies. Input changes mid-frame are invisible until the next frame_end.
- **Hit test.** An object hits when it is active, x ≥ ox, x < ox+W, y ≥ oy and y < oy+H. The sums are computed in X_W+1 / Y_W+1 bits, so there is no wrap-around: an object at x=1000 never covers x=5.
- **Priority.** Colour priority, high to low: enemy > enemy bullet > player > player bullet > background.
- **Collision accumulation.** Only valid pixels are evaluated.
  - enemy_acc[i] |= hit_enemy[i] & (any player-bullet hit)
  - pb_acc[j] |= hit_pb[j] & (any enemy hit)
  - pl_acc |= hit_player & (any enemy hit | any enemy-bullet hit)
- **Frame publish.** frame_end travels down the pipeline as a marker. When the marker reaches stage 2:
  - The accumulators, including the hits of that same cycle, are copied to the outputs.
  - coll_valid pulses for one cycle.
  - The accumulators clear.
  - The outputs hold their values until the next publish.
- **Reset values.** All outputs are 0. All shadow state flags are 0, so the screen renders as background. Accumulators and pipeline valids are 0.

## Timing
- **Stage 1 (edge t+1).** The request sampled at edge t is compared against the shadow contents as they were before edge t, so a pixel coincident with frame_end uses the old frame's objects. Hit vectors, the valid bit and the frame marker are registered.
- **Stage 2 (edge t+2).** Priority encode and accumulator update. pixelState and pix_valid_out are registered.
- **Latency.** Fixed at 2 cycles, throughput 1 pixel/cycle, no backpressure. pix_valid_out equals pix_valid_in delayed by 2. pixelState is 0 whenever pix_valid_out=0.
- **coll_valid.** Asserts exactly 2 cycles after frame_end. When frame_end pulses on consecutive cycles, each pulse publishes separately; the second publish covers only the pixels between the two pulses.
- **Mid-operation reset.** Reset flushes in-flight pixels and markers and clears the accumulators. No coll_valid is produced until 2 cycles after the next frame_end following reset.

## Test plan
- **Enemy rendering.** Enemy 0 at (100,50) and active, after frame_end. Pixel (100,50) → pixelState=4 at t+2. Pixel (135,73) → 4. Pixels (136,50) and (100,74) → 0.
- **Priority.** Player at x=200 plus enemy bullet 5 at (210,285). Pixel (210,290) → 3. Pixel (220,290) → 1. Pixel (199,290) → 0.
- **No wrap-around.** Enemy at x=1000, y=50. Pixel (5,55) → 0. Pixel (1023,55) → 4.
- **Collision flags.** Player bullet 3 at (110,60) overlaps enemy 0. Scan the full frame, then pulse frame_end. At +2 cycles: coll_valid=1, enemy_hit=15'h0001, pbullet_hit=15'h0008, player_hit=0. The next frame without the overlap publishes all zeros.
- **Snapshot.** Move enemy 0 to (300,50) mid-frame without frame_end. Pixel (100,50) → still 4. Pulse frame_end; afterwards pixel (100,50) → 0 and pixel (300,50) → 4.
- **Mid-frame reset.** Assert reset mid-frame with an overlap already accumulated. pix_valid_out=0 and pixelState=0 on the next cycle. The next frame_end with no objects publishes all-zero vectors.
